// File: rtl/reg_file.sv
// reg_file: parameterised register file, two datapath read ports, one debug read port,
// one write port with optional write-to-read forwarding and a committed-write counter. Rev 1.0
`default_nettype none

module reg_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int BYPASS = 0,
  localparam int c_AW  = ($clog2(DEPTH) > 5) ? $clog2(DEPTH) : 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [c_AW-1:0]  A1,
  input  logic [c_AW-1:0]  A2,
  input  logic [c_AW-1:0]  A3,
  input  logic [WIDTH-1:0] WD3,
  input  logic             WE3,
  input  logic [c_AW-1:0]  A4,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [WIDTH-1:0] RD4,
  output logic [15:0]      WrCount
);

  localparam int              c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0]   c_DEPTH = DEPTH[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [15:0]      r_wr_count;

  logic             w_wr_en;
  logic [WIDTH-1:0] w_rd1_mem;
  logic [WIDTH-1:0] w_rd2_mem;

  // Register 0 and addresses beyond DEPTH are never backed by storage.
  function automatic logic addr_live(input logic [c_AW-1:0] a);
    return ({1'b0, a} < c_DEPTH) && (a != '0);
  endfunction

  function automatic logic [WIDTH-1:0] mem_read(input logic [c_AW-1:0] a);
    return addr_live(a) ? r_mem[a[c_IW-1:0]] : '0;
  endfunction

  assign w_wr_en   = rst_n && WE3 && addr_live(A3);
  assign w_rd1_mem = mem_read(A1);
  assign w_rd2_mem = mem_read(A2);
  assign RD4       = mem_read(A4);
  assign WrCount   = r_wr_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_en) begin
      r_mem[A3[c_IW-1:0]] <= WD3;
      r_wr_count          <= r_wr_count + 16'd1;
    end
  end

  // Forwarding only applies to writes that will actually commit this edge.
  generate
    if (BYPASS != 0) begin : g_bypass
      assign RD1 = (w_wr_en && (A3 == A1)) ? WD3 : w_rd1_mem;
      assign RD2 = (w_wr_en && (A3 == A2)) ? WD3 : w_rd2_mem;
    end else begin : g_no_bypass
      assign RD1 = w_rd1_mem;
      assign RD2 = w_rd2_mem;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file (default, forwarding and DEPTH=16 builds).
`default_nettype none

module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1, A2, A3, A4;
  logic [31:0] WD3;
  logic        WE3;

  logic [31:0] rd1, rd2, rd4;
  logic [15:0] wc;
  logic [31:0] rd1_bp, rd2_bp, rd4_bp;
  logic [15:0] wc_bp;
  logic [31:0] rd1_s, rd2_s, rd4_s;
  logic [15:0] wc_s;

  int checks = 0;
  int errors = 0;

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3), .A4(A4),
    .RD1(rd1), .RD2(rd2), .RD4(rd4), .WrCount(wc)
  );

  reg_file #(.BYPASS(1)) dut_bp (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3), .A4(A4),
    .RD1(rd1_bp), .RD2(rd2_bp), .RD4(rd4_bp), .WrCount(wc_bp)
  );

  reg_file #(.DEPTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3), .A4(A4),
    .RD1(rd1_s), .RD2(rd2_s), .RD4(rd4_s), .WrCount(wc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    A3 = a; WD3 = d; WE3 = 1'b1;
    edge1();
    WE3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; WE3 = 1'b0; WD3 = '0;
    A1 = '0; A2 = '0; A3 = '0; A4 = '0;

    // Reset for two edges, then sweep every address on every port.
    repeat (2) edge1();
    check("reset_wrcount", {16'h0, wc}, 32'h0);
    check("reset_wrcount_bp", {16'h0, wc_bp}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(i); A4 = 5'(i);
      #1;
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
      check("reset_rd4", rd4, 32'h0);
      check("reset_rd1_bp", rd1_bp, 32'h0);
    end
    rst_n = 1'b1;

    // Basic write then read on all three ports.
    wr(5'd5, 32'hDEADBEEF);
    A1 = 5'd5; A2 = 5'd5; A4 = 5'd5;
    #1;
    check("wr5_rd1", rd1, 32'hDEADBEEF);
    check("wr5_rd2", rd2, 32'hDEADBEEF);
    check("wr5_rd4", rd4, 32'hDEADBEEF);
    check("wr5_count", {16'h0, wc}, 32'd1);

    // Register 0 discards writes and is never forwarded.
    A1 = 5'd0; A3 = 5'd0; WD3 = 32'hFFFFFFFF; WE3 = 1'b1;
    #1;
    check("r0_bp_before", rd1_bp, 32'h0);
    edge1();
    WE3 = 1'b0;
    check("r0_rd1", rd1, 32'h0);
    check("r0_count", {16'h0, wc}, 32'd1);

    // Read-during-write on port 1.
    wr(5'd7, 32'h11);
    A1 = 5'd7; A4 = 5'd7; A3 = 5'd7; WD3 = 32'h22; WE3 = 1'b1;
    #1;
    check("rdw_nobp_before", rd1, 32'h11);
    check("rdw_bp_before", rd1_bp, 32'h22);
    check("rdw_bp_rd4_not_fwd", rd4_bp, 32'h11);
    edge1();
    WE3 = 1'b0;
    check("rdw_nobp_after", rd1, 32'h22);
    check("rdw_bp_after", rd1_bp, 32'h22);
    check("rdw_count", {16'h0, wc}, 32'd3);

    // Forwarding on port 2 only for the matching address.
    A1 = 5'd5; A2 = 5'd9; A3 = 5'd9; WD3 = 32'h99; WE3 = 1'b1;
    #1;
    check("bp2_rd2", rd2_bp, 32'h99);
    check("bp2_rd1_other", rd1_bp, 32'hDEADBEEF);
    check("bp2_nobp_rd2", rd2, 32'h0);
    edge1();
    WE3 = 1'b0;

    // Reset with a simultaneous write: forwarding disabled, write lost.
    rst_n = 1'b0; A1 = 5'd7; A3 = 5'd7; WD3 = 32'h55; WE3 = 1'b1;
    #1;
    check("rst_bp_disabled", rd1_bp, 32'h22);
    edge1();
    WE3 = 1'b0;
    check("rst_rd7", rd1, 32'h0);
    check("rst_count", {16'h0, wc}, 32'h0);

    // First cycle after deassertion commits.
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) wr(5'(i), 32'(i) * 32'h101);
    A1 = 5'd10; A2 = 5'd3;
    #1;
    check("ten_rd10", rd1, 32'h0A0A);
    check("ten_rd3", rd2, 32'h0303);
    check("ten_count", {16'h0, wc}, 32'd10);

    // Mid-sequence reset with colliding write to reg 3.
    rst_n = 1'b0; A3 = 5'd3; WD3 = 32'h55; WE3 = 1'b1;
    edge1();
    WE3 = 1'b0;
    check("rst2_count", {16'h0, wc}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(i); A4 = 5'(i);
      #1;
      check("rst2_rd1", rd1, 32'h0);
      check("rst2_rd4", rd4, 32'h0);
    end

    // Deassert reset and write in the same cycle.
    rst_n = 1'b1; A3 = 5'd4; WD3 = 32'h44; WE3 = 1'b1; A1 = 5'd4;
    edge1();
    WE3 = 1'b0;
    check("deassert_wr", rd1, 32'h44);
    check("deassert_count", {16'h0, wc}, 32'd1);

    // Counter wrap: 65534 more writes reach 0xFFFF, one more wraps to 0.
    A3 = 5'd1; WD3 = 32'hA5A5A5A5; WE3 = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("wrap_ffff", {16'h0, wc}, 32'h0000FFFF);
    edge1();
    WE3 = 1'b0;
    check("wrap_zero", {16'h0, wc}, 32'h0);
    edge1();
    check("hold_zero", {16'h0, wc}, 32'h0);
    A1 = 5'd1;
    #1;
    check("wrap_rd1", rd1, 32'hA5A5A5A5);

    // Out-of-range address on the DEPTH=16 build.
    check("s_count_pre", {16'h0, wc_s}, 32'h0);
    wr(5'd20, 32'h77);
    A1 = 5'd20;
    #1;
    check("oor_default_rd", rd1, 32'h77);
    check("oor_small_rd", rd1_s, 32'h0);
    check("oor_small_count", {16'h0, wc_s}, 32'h0);
    check("oor_default_count", {16'h0, wc}, 32'd1);
    A1 = 5'd4;
    #1;
    check("oor_small_alias", rd1_s, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and data port, in bits.
REQ-002 Parameter DEPTH, default 32: number of registers; address width is log2(DEPTH), 5 at default.
REQ-003 Parameter BYPASS, default 0: when 1, same-cycle write data is forwarded to read ports.
REQ-004 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 A1  input  5  read address, port 1; its data feeds ALU SrcA.
REQ-007 A2  input  5  read address, port 2; its data feeds the SrcB mux.
REQ-008 A3  input  5  write address.
REQ-009 WD3  input  WIDTH  write data, i.e. ALUResult or memory read data.
REQ-010 WE3  input  1  write enable.
REQ-011 A4  input  5  debug read address.
REQ-012 RD1  output  WIDTH  read data, port 1.
REQ-013 RD2  output  WIDTH  read data, port 2.
REQ-014 RD4  output  WIDTH  debug read data.
REQ-015 WrCount  output  16  count of committed writes since reset.

Function
REQ-016 Storage SHALL be DEPTH registers of WIDTH bits; register 0 SHALL always read 0.
REQ-017 Write SHALL commit on a rising clk edge when rst_n=1, WE3=1 and A3!=0: reg[A3] <= WD3.
REQ-018 A write with A3=0 SHALL be discarded and SHALL NOT increment WrCount.
REQ-019 RD1, RD2 and RD4 SHALL be combinational reads, with zero-cycle latency from address to data.
REQ-020 With BYPASS=0, a read of the address being written SHALL return the old value until the edge, then the new value.
REQ-021 With BYPASS=1, RD1 SHALL equal WD3 when WE3=1, rst_n=1, A3=A1 and A3!=0; RD2 SHALL follow the same rule against A2; RD4 is never bypassed.
REQ-022 BYPASS=1 creates a combinational loop RD1->ALU->WD3 in the single-cycle datapath; the single-cycle top SHALL instantiate with BYPASS=0.
REQ-023 WrCount SHALL increment by 1 on each committed write, wrap from 0xFFFF to 0x0000, and hold otherwise.
REQ-024 Ports 1, 2 and 4 SHALL be independent; the same address on several ports returns identical data.
REQ-025 Addresses at or above DEPTH, for non-default DEPTH, SHALL read 0, and writes to them SHALL be discarded.
REQ-026 No X SHALL propagate from storage to outputs after the first reset edge.

Reset
REQ-027 On a rising clk edge with rst_n=0, all registers SHALL clear to 0 and WrCount SHALL clear to 0.
REQ-028 rst_n=0 SHALL take priority over a simultaneous WE3=1; that write is lost and not counted.
REQ-029 While rst_n=0, the bypass path SHALL be disabled; reads return stored contents, which are 0 after the first reset edge.
REQ-030 Reset deassertion SHALL take effect at the next edge; a write presented in the first cycle with rst_n=1 SHALL commit.

Verification
REQ-031 Reset: rst_n=0 for 2 edges, then sweep A1/A2/A4 over 0..31 -> all reads 0, WrCount=0.
REQ-032 Write/read: write 0xDEADBEEF to reg 5, then A1=5, A2=5, A4=5 -> all three ports return 0xDEADBEEF; WrCount=1.
REQ-033 Register 0: WE3=1, A3=0, WD3=0xFFFFFFFF -> RD1 at A1=0 returns 0; WrCount unchanged.
REQ-034 Read-during-write, BYPASS=0: reg 7=0x11, then WE3=1, A3=7, WD3=0x22, A1=7 -> RD1=0x11 before the edge and 0x22 after it; repeat with BYPASS=1 -> RD1=0x22 before the edge.
REQ-035 Reset priority: rst_n=0 with WE3=1, A3=3, WD3=0x55 -> reg 3 reads 0 and WrCount=0 after the edge; reset issued mid-sequence after 10 writes clears everything.
REQ-036 Counter wrap: preload via 65535 writes to reg 1, then one more write -> WrCount goes 0xFFFF -> 0x0000.
